// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and op decode for the mul/div unit
//
// Contents:
//   OP_MUL..OP_MODU  3-bit operation codes (7 is reserved and decodes as MUL)
//   state_t          control FSM states IDLE / CALC / DONE
//   op_info_t        decoded operation attributes
//   decode_op()      maps an op code onto op_info_t

package muldiv_pkg;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULH  = 3'd1;
  localparam logic [2:0] OP_MULHU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MOD   = 3'd5;
  localparam logic [2:0] OP_MODU  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic is_div;     // divide family (quotient or remainder)
    logic is_rem;     // return remainder instead of quotient
    logic is_signed;  // operands are two's complement
    logic is_high;    // multiply returns the upper half of the product
  } op_info_t;

  // MUL is decoded as signed: the low half of the product does not depend on
  // operand signedness, so this only keeps the sign pre/post path uniform.
  function automatic op_info_t decode_op(input logic [2:0] op);
    op_info_t info;
    info = '0;
    case (op)
      OP_MULH: begin
        info.is_signed = 1'b1;
        info.is_high   = 1'b1;
      end
      OP_MULHU: info.is_high = 1'b1;
      OP_DIV: begin
        info.is_div    = 1'b1;
        info.is_signed = 1'b1;
      end
      OP_DIVU: info.is_div = 1'b1;
      OP_MOD: begin
        info.is_div    = 1'b1;
        info.is_rem    = 1'b1;
        info.is_signed = 1'b1;
      end
      OP_MODU: begin
        info.is_div = 1'b1;
        info.is_rem = 1'b1;
      end
      default: info.is_signed = 1'b1;  // OP_MUL and reserved 7
    endcase
    return info;
  endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// rtl/muldiv_shift_core.sv - one-bit-per-cycle shift-add / restoring-divide datapath
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        load operands and begin WIDTH iterations (overrides any run)
//   is_div       1: restoring divide, 0: shift-add multiply
//   a, b         unsigned magnitudes (multiplicand/multiplier, dividend/divisor)
//   done         iteration counter is zero; results below are final
//   product      2*WIDTH product of a*b
//   quotient     a / b
//   remainder    a % b

module muldiv_shift_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  // acc is the product high half / partial remainder, lo is the product low
  // half (multiplier shifting out) / dividend shifting out, quotient in.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] b_q;
  logic             div_q;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    add_sum = {1'b0, acc} + (lo[0] ? {1'b0, b_q} : '0);
    shifted = {acc, lo[WIDTH-1]};
    // acc < b always holds, so shifted < 2*b: diff[WIDTH] is the borrow.
    diff    = shifted - {1'b0, b_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      lo    <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      count <= '0;
    end else if (start) begin
      acc   <= '0;
      lo    <= a;
      b_q   <= b;
      div_q <= is_div;
      count <= CW'(WIDTH);
    end else if (count != '0) begin
      count <= count - 1'b1;
      if (div_q) begin
        if (!diff[WIDTH]) begin
          acc <= diff[WIDTH-1:0];
          lo  <= {lo[WIDTH-2:0], 1'b1};
        end else begin
          acc <= shifted[WIDTH-1:0];
          lo  <= {lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= add_sum[WIDTH:1];
        lo  <= {add_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

  assign done      = (count == '0);
  assign product   = {acc, lo};
  assign quotient  = lo;
  assign remainder = acc;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle integer multiply/divide unit with valid/ready handshake
//
// Optional build macro: MULDIV_EARLY_OUT_EN (divide by zero skips the iterations)
//
// Parameters:
//   WIDTH        operand/result width, even, 4..64
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   in_valid     request valid
//   in_ready     request accepted when high (IDLE only)
//   in_op        OP_MUL..OP_MODU
//   in_a, in_b   source operands, sampled only at acceptance
//   flush        abort any operation; return to IDLE on the next edge
//   out_valid    result valid (DONE)
//   out_ready    consumer takes the result
//   out_result   result, held stable while in DONE
//   busy         high in CALC or DONE

module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state;
  state_t state_next;

  op_info_t in_info;
  op_info_t info_q;

  logic             accept;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             b_zero;
  logic             overflow;
  logic             early;

  logic [WIDTH-1:0] a_raw_q;
  logic             q_neg_q;    // quotient / product sign
  logic             r_neg_q;    // remainder sign follows the dividend
  logic             div_zero_q;
  logic             ovf_q;
  logic             skip_q;

  logic               core_done;
  logic [2*WIDTH-1:0] core_product;
  logic [WIDTH-1:0]   core_quotient;
  logic [WIDTH-1:0]   core_remainder;

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   result_next;
  logic               load_result;

  // ---------------- request decode and sign pre-processing ----------------
  always_comb begin
    in_info  = decode_op(in_op);
    accept   = in_valid && (state == IDLE) && !flush;
    sa       = in_info.is_signed && in_a[WIDTH-1];
    sb       = in_info.is_signed && in_b[WIDTH-1];
    mag_a    = sa ? (~in_a + 1'b1) : in_a;
    mag_b    = sb ? (~in_b + 1'b1) : in_b;
    b_zero   = (in_b == '0);
    overflow = in_info.is_signed && in_info.is_div &&
               (in_a == MIN_VAL) && (in_b == '1);
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign early = in_info.is_div && b_zero;
`else
  assign early = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  // An early-out request still spends one cycle in CALC; that cycle
  // registers the forced result, so out_valid rises one edge after accept.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (skip_q || core_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // ---------------- request capture ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      info_q     <= '0;
      a_raw_q    <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      skip_q     <= 1'b0;
    end else if (accept) begin
      info_q     <= in_info;
      a_raw_q    <= in_a;
      q_neg_q    <= sa ^ sb;
      r_neg_q    <= sa;
      div_zero_q <= in_info.is_div && b_zero;
      ovf_q      <= overflow;
      skip_q     <= early;
    end
  end

  muldiv_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (accept && !early),
    .is_div    (in_info.is_div),
    .a         (mag_a),
    .b         (mag_b),
    .done      (core_done),
    .product   (core_product),
    .quotient  (core_quotient),
    .remainder (core_remainder)
  );

  // ---------------- sign post-processing and special cases ----------------
  always_comb begin
    prod_s = q_neg_q ? (~core_product + 1'b1) : core_product;
    quot_s = q_neg_q ? (~core_quotient + 1'b1) : core_quotient;
    rem_s  = r_neg_q ? (~core_remainder + 1'b1) : core_remainder;
    if (info_q.is_div) begin
      if (div_zero_q)
        result_next = info_q.is_rem ? a_raw_q : '1;
      else if (ovf_q)
        result_next = info_q.is_rem ? '0 : MIN_VAL;
      else
        result_next = info_q.is_rem ? rem_s : quot_s;
    end else begin
      result_next = info_q.is_high ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
    end
    load_result = (state == CALC) && (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset)            out_result <= '0;
    else if (load_result) out_result <= result_next;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit (WIDTH=32)

module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_DZ = 1;
`else
  localparam int LAT_DZ = W + 1;
`endif

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         busy;

  int checks;
  int errors;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request, let it be accepted, then wait for out_valid.
  // cyc counts edges after the accept edge until out_valid is seen.
  task automatic start_and_wait(input string tag, input logic [2:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output int cyc);
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input int lat);
    int cyc;
    start_and_wait(tag, op, a, b, cyc);
    chk({tag, "_lat"}, 64'(cyc), 64'(lat));
    chk({tag, "_res"}, 64'(out_result), 64'(exp));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [W-1:0] held;

    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_b      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // multiply
    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT);
    run_op("mulhu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
    run_op("mulh_neg", 3'd1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, LAT);

    // divide
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT);
    run_op("mod_neg", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT);
    run_op("divu", 3'd4, 32'd100, 32'd7, 32'd14, LAT);
    run_op("modu", 3'd6, 32'd100, 32'd7, 32'd2, LAT);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT);
    run_op("mod_ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT);

    // divide by zero
    run_op("divu_z", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_DZ);
    run_op("modu_z", 3'd6, 32'd5, 32'd0, 32'd5, LAT_DZ);
    run_op("mod_z", 3'd5, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, LAT_DZ);
    run_op("div_z", 3'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, LAT_DZ);

    // flush 10 cycles into a DIV with a simultaneous request
    @(negedge clk);
    in_op = 3'd3; in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd4; in_a = 32'd9; in_b = 32'd3;
    @(posedge clk);
    #1;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    run_op("post_flush", 3'd4, 32'd100, 32'd7, 32'd14, LAT);

    // backpressure in DONE with request inputs wiggling
    start_and_wait("bp", 3'd6, 32'd23, 32'd5, cyc);
    chk("bp_lat", 64'(cyc), 64'(LAT));
    held = out_result;
    chk("bp_res", 64'(held), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_op = 3'd0; in_a = $urandom; in_b = $urandom;
      @(posedge clk);
      #1;
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_result_hold", 64'(out_result), 64'(held));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_release_busy", 64'(busy), 64'd0);
    chk("bp_release_valid", 64'(out_valid), 64'd0);

    // reset in the middle of an operation
    @(negedge clk);
    in_op = 3'd0; in_a = 32'd3; in_b = 32'd4; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_result", 64'(seen), 64'd0);
    run_op("post_rst", 3'd0, 32'd3, 32'd4, 32'd12, LAT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
